// File: rtl/mario_anim_ctrl.sv
// Mario pose sequencer and 32x32 sprite pixel pipeline (3-clock scan-to-pixel latency).
// Define MARIO_MIRROR_EN to reuse the right-facing ROMs for left poses via horizontal mirroring.
module mario_anim_ctrl #(
    parameter int          SPR_DIM    = 32,
    parameter int          ADDR_W     = 10,
    parameter int          WALK_TICKS = 8,
    parameter logic [11:0] TRANSP_KEY = 12'hF0F
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_tick,
    input  logic              move_left,
    input  logic              move_right,
    input  logic              airborne,
    input  logic              bright,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic [9:0]        mario_x,
    input  logic [9:0]        mario_y,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [2:0]        rom_sel,
    input  logic [11:0]       rom_pixel,
    output logic              pix_valid,
    output logic [11:0]       pix_rgb,
    output logic [1:0]        pose_state
);
    // state  | meaning
    // IDLE   | standing, no direction held
    // WALK_A | walk stride frame (walk ROM)
    // WALK_B | walk stride frame (idle ROM)
    // JUMP   | airborne
    localparam int LW = $clog2(SPR_DIM);
    localparam int CW = (WALK_TICKS > 1) ? $clog2(WALK_TICKS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK_A = 2'd1,
        WALK_B = 2'd2,
        JUMP   = 2'd3
    } pose_t;

    pose_t         state, state_nx;
    logic          facing_left, facing_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    sel_nx;
    logic          one_dir;

    assign one_dir    = move_left ^ move_right;
    assign pose_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            facing_left <= 1'b0;
            cnt         <= '0;
            rom_sel     <= 3'd0;
        end else begin
            state       <= state_nx;
            facing_left <= facing_nx;
            cnt         <= cnt_nx;
            rom_sel     <= sel_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        facing_nx = facing_left;
        cnt_nx    = cnt;
        sel_nx    = rom_sel;
        if (frame_tick) begin
            if (one_dir) facing_nx = move_left;
            if (airborne) begin
                state_nx = JUMP;
                cnt_nx   = '0;
            end else if (one_dir) begin
                if (state == IDLE || state == JUMP) begin
                    state_nx = WALK_A;
                    cnt_nx   = '0;
                end else if (cnt == CW'(WALK_TICKS - 1)) begin
                    state_nx = (state == WALK_A) ? WALK_B : WALK_A;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end else begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            case (state_nx)
                WALK_A:  sel_nx[2:1] = 2'd1;
                JUMP:    sel_nx[2:1] = 2'd2;
                default: sel_nx[2:1] = 2'd0;
            endcase
`ifdef MARIO_MIRROR_EN
            sel_nx[0] = 1'b0;
`else
            sel_nx[0] = facing_nx;
`endif
        end
    end

    // 11-bit differences: a scan position left of/above the sprite goes negative and sets high bits
    logic [10:0]       dx, dy;
    logic              hit, hit_d1, hit_d2;
    logic [LW-1:0]     col;
    logic [ADDR_W-1:0] addr_nx;

    assign dx  = {1'b0, hcount} - {1'b0, mario_x};
    assign dy  = {1'b0, vcount} - {1'b0, mario_y};
    assign hit = bright && (dx[10:LW] == '0) && (dy[10:LW] == '0);
`ifdef MARIO_MIRROR_EN
    assign col = facing_left ? ~dx[LW-1:0] : dx[LW-1:0];
`else
    assign col = dx[LW-1:0];
`endif
    assign addr_nx = {dy[LW-1:0], col};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr  <= '0;
            hit_d1    <= 1'b0;
            hit_d2    <= 1'b0;
            pix_valid <= 1'b0;
            pix_rgb   <= 12'h000;
        end else begin
            if (hit) rom_addr <= addr_nx;
            hit_d1 <= hit;
            hit_d2 <= hit_d1;
            if (hit_d2 && rom_pixel != TRANSP_KEY) begin
                pix_valid <= 1'b1;
                pix_rgb   <= rom_pixel;
            end else begin
                pix_valid <= 1'b0;
                pix_rgb   <= 12'h000;
            end
        end
    end
endmodule

// File: tb/tb_mario_anim_ctrl.sv
// Bench for mario_anim_ctrl: pose sequencing checks plus a queued scoreboard on the pixel path.
module tb_mario_anim_ctrl;
`ifdef MARIO_MIRROR_EN
    localparam bit MIR = 1'b1;
`else
    localparam bit MIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_tick = 1'b0, move_left = 1'b0, move_right = 1'b0, airborne = 1'b0;
    logic        bright = 1'b0;
    logic [9:0]  hcount = '0, vcount = '0, mario_x = '0, mario_y = '0;
    logic [9:0]  rom_addr;
    logic [2:0]  rom_sel;
    logic [11:0] rom_pixel = '0;
    logic        pix_valid;
    logic [11:0] pix_rgb;
    logic [1:0]  pose_state;

    int checks = 0;
    int failures = 0;

    logic [12:0] q[$];
    int          model_addr = 0;
    bit          exp_left = 1'b0;
    bit          rom_force = 1'b0;
    logic [11:0] rom_force_val = '0;

    mario_anim_ctrl dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .move_left(move_left), .move_right(move_right), .airborne(airborne),
        .bright(bright), .hcount(hcount), .vcount(vcount),
        .mario_x(mario_x), .mario_y(mario_y), .rom_addr(rom_addr),
        .rom_sel(rom_sel), .rom_pixel(rom_pixel), .pix_valid(pix_valid),
        .pix_rgb(pix_rgb), .pose_state(pose_state)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_fn(input logic [9:0] a);
        return (a[3:0] == 4'd7) ? 12'hF0F : {2'b01, a};
    endfunction

    // external pose ROM with one clock of read latency
    always @(posedge clk) rom_pixel <= rom_force ? rom_force_val : rom_fn(rom_addr);

    function automatic logic [2:0] sel_for(input int pose, input bit left);
        int base;
        base = (pose == 1) ? 2 : (pose == 3) ? 4 : 0;
        return 3'(base + ((left && !MIR) ? 1 : 0));
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic check_pose(input string name, input int pose, input bit left);
        logic [2:0] es;
        es = sel_for(pose, left);
        checks++;
        if (pose_state !== 2'(pose)) begin
            failures++;
            $display("FAIL %s pose_state got=%0d want=%0d", name, pose_state, pose);
        end
        checks++;
        if (rom_sel !== es) begin
            failures++;
            $display("FAIL %s rom_sel got=%0d want=%0d", name, rom_sel, es);
        end
    endtask

    // Scans columns x0..x1 on row y; expected pixels queue up on drive and are compared 3 clocks later.
    task automatic scan(input int x0, input int x1, input int y, input int mx, input int my);
        int n, h, dx, dy, col;
        bit br, hit;
        logic [11:0] pix;
        logic [12:0] e;
        n = x1 - x0 + 1;
        mario_x = 10'(mx);
        mario_y = 10'(my);
        for (int j = 0; j < n + 3; j++) begin
            step();
            checks++;
            if (rom_addr !== 10'(model_addr)) begin
                failures++;
                $display("FAIL scan_addr h=%0d got=%0d want=%0d", x0 + j - 1, rom_addr, model_addr);
            end
            if (q.size() >= 3) begin
                e = q.pop_front();
                checks++;
                if ({pix_valid, pix_rgb} !== e) begin
                    failures++;
                    $display("FAIL scan_pix h=%0d got=%b/%h want=%b/%h",
                             x0 + j - 3, pix_valid, pix_rgb, e[12], e[11:0]);
                end
            end
            h  = (j < n) ? x0 + j : 0;
            br = (j < n) && (h < 640);
            hcount = 10'(h);
            vcount = 10'(y);
            bright = br;
            dx = h - mx;
            dy = y - my;
            hit = br && dx >= 0 && dx < 32 && dy >= 0 && dy < 32;
            e = 13'h0;
            if (hit) begin
                col = (MIR && exp_left) ? 31 - dx : dx;
                model_addr = dy * 32 + col;
                pix = rom_force ? rom_force_val : rom_fn(10'(model_addr));
                if (pix != 12'hF0F) e = {1'b1, pix};
            end
            q.push_back(e);
        end
        q.delete();
        bright = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({pix_valid, pix_rgb, rom_addr} !== 23'h0) begin
            failures++;
            $display("FAIL reset_out got=%b/%h/%0d want=0/000/0", pix_valid, pix_rgb, rom_addr);
        end
        reset_n = 1'b1;
        repeat (2) step();
        check_pose("reset_pose", 0, 1'b0);
        model_addr = 0;
        exp_left = 1'b0;
    endtask

    task automatic test_walk;
        int pose;
        move_right = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            do_tick();
            pose = (((k - 1) / 8) % 2 == 0) ? 1 : 2;
            check_pose($sformatf("walk_tick%0d", k), pose, 1'b0);
            repeat (2) step();
        end
        move_right = 1'b0;
        exp_left = 1'b0;
    endtask

    task automatic test_jump;
        move_left = 1'b1;
        airborne = 1'b1;
        do_tick();
        move_left = 1'b0;
        check_pose("jump_left", 3, 1'b1);
        airborne = 1'b0;
        repeat (5) step();
        check_pose("jump_hold_no_tick", 3, 1'b1);
        do_tick();
        check_pose("idle_keep_left", 0, 1'b1);
        exp_left = 1'b1;
    endtask

    task automatic test_scan;
        scan(99, 132, 51, 100, 50);
        scan(95, 105, 49, 100, 50);
        scan(120, 135, 81, 100, 50);
        check_pose("scan_sel_stable", 0, 1'b1);
    endtask

    task automatic test_key;
        rom_force = 1'b1;
        rom_force_val = 12'hF0F;
        scan(110, 113, 60, 100, 50);
        rom_force_val = 12'hE21;
        scan(110, 113, 60, 100, 50);
        rom_force = 1'b0;
    endtask

    task automatic test_reset_mid;
        move_right = 1'b1;
        do_tick();
        move_right = 1'b0;
        exp_left = 1'b0;
        rom_force = 1'b1;
        rom_force_val = 12'hE21;
        mario_x = 10'd100;
        mario_y = 10'd50;
        hcount = 10'd105;
        vcount = 10'd55;
        bright = 1'b1;
        repeat (4) step();
        checks++;
        if ({pix_valid, pix_rgb} !== {1'b1, 12'hE21}) begin
            failures++;
            $display("FAIL midreset_pre got=%b/%h want=1/e21", pix_valid, pix_rgb);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({pix_valid, pix_rgb, rom_addr} !== 23'h0) begin
            failures++;
            $display("FAIL midreset_async got=%b/%h/%0d want=0/000/0", pix_valid, pix_rgb, rom_addr);
        end
        check_pose("midreset_async", 0, 1'b0);
        bright = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (3) step();
        check_pose("midreset_release", 0, 1'b0);
        rom_force = 1'b0;
        model_addr = 0;
    endtask

    task automatic test_mirror;
        move_left = 1'b1;
        do_tick();
        move_left = 1'b0;
        exp_left = 1'b1;
        check_pose("mirror_walk_left", 1, 1'b1);
        scan(203, 203, 100, 200, 100);
        if (MIR) begin
            checks++;
            if (rom_addr !== 10'd28) begin
                failures++;
                $display("FAIL mirror_addr got=%0d want=28", rom_addr);
            end
        end
        scan(615, 660, 300, 620, 290);
        move_left = 1'b1;
        move_right = 1'b1;
        do_tick();
        move_left = 1'b0;
        move_right = 1'b0;
        check_pose("both_keys_idle", 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_walk();
        test_jump();
        test_scan();
        test_key();
        test_reset_mid();
        test_mirror();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
